// File: rtl/main_mem_ctrl_pkg.sv
// Shared constants and state type for the main memory controller slice.
package PARAMS_pkg;

  localparam int ADDR_SIZE  = 32;
  localparam int LINE_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

endpackage

// File: rtl/main_mem_ctrl_line_array.sv
// Line-wide storage: one synchronous write port, one registered read port.
// The storage itself has no reset, so its contents survive a controller reset.
module mem_line_array #(
  parameter  int LINES = 1024,
  parameter  int BITS  = 512,
  localparam int IW    = $clog2(LINES)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            rd_en,
  input  logic            rd_clr,
  input  logic [IW-1:0]   rd_addr,
  output logic [BITS-1:0] rd_data
);

  logic [BITS-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is clearable; it holds the last fill otherwise.
  always_ff @(posedge clk) begin
    if (rd_clr)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// Fixed-latency line memory controller: accepts one fill or write-back at a
// time, waits MEM_LATENCY cycles, then pulses mem_valid_o for one cycle.
module main_mem_ctrl
  import PARAMS_pkg::*;
#(
  parameter  int LINE_BYTES  = PARAMS_pkg::LINE_BYTES,
  parameter  int MEM_LINES   = 1024,
  parameter  int MEM_LATENCY = 5,
  localparam int LINE_BITS   = LINE_BYTES * 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_op_en_i,
  input  logic                 mem_op_rd_wr_i,
  input  logic [ADDR_SIZE-1:0] mem_addr_i,
  input  logic [LINE_BITS-1:0] mem_data_i,
  output logic                 mem_ready_o,
  output logic                 mem_valid_o,
  output logic [LINE_BITS-1:0] mem_data_o
);

  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int INDEX_BITS  = $clog2(MEM_LINES);

  mem_state_t            state;
  mem_state_t            next_state;
  logic [7:0]            cnt;
  logic                  req_rd_wr;
  logic [INDEX_BITS-1:0] req_index;
  logic [LINE_BITS-1:0]  req_data;
  logic                  accept;
  logic                  done;

  assign mem_ready_o = reset_n && (state == IDLE);
  assign accept      = mem_op_en_i && mem_ready_o;
  assign done        = (state == WAIT) && (cnt == 8'd0);
  assign mem_valid_o = (state == RESP);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = WAIT;
      WAIT:    if (cnt == 8'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture and latency countdown; upper address bits alias away.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      req_rd_wr <= 1'b0;
      req_index <= '0;
      req_data  <= '0;
    end else if (accept) begin
      cnt       <= 8'(MEM_LATENCY - 1);
      req_rd_wr <= mem_op_rd_wr_i;
      req_index <= mem_addr_i[OFFSET_BITS +: INDEX_BITS];
      req_data  <= mem_data_i;
    end else if ((state == WAIT) && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Storage is touched only on the WAIT->RESP edge, and never on a reset edge.
  mem_line_array #(
    .LINES (MEM_LINES),
    .BITS  (LINE_BITS)
  ) u_array (
    .clk     (clk),
    .wr_en   (done && req_rd_wr && reset_n),
    .wr_addr (req_index),
    .wr_data (req_data),
    .rd_en   (done && !req_rd_wr && reset_n),
    .rd_clr  (!reset_n),
    .rd_addr (req_index),
    .rd_data (mem_data_o)
  );

endmodule
